// File: rtl/ipsl_pcie_dma_mwr_rx_parser.sv
// rtl/ipsl_pcie_dma_mwr_rx_parser.sv - MWr TLP filter, payload repacker and store-and-forward burst replayer.
// Optional drop counter output enabled by IPSL_PCIE_MWR_DROP_CNT_EN.
module ipsl_pcie_dma_mwr_rx_parser #(
    parameter int FIFO_DEPTH = 64,
    parameter int MAX_LEN_DW = 256
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_axis_master_tvalid,
    output logic         o_axis_master_tready,
    input  logic [127:0] i_axis_master_tdata,
    input  logic [3:0]   i_axis_master_tkeep,
    input  logic         i_axis_master_tlast,
    input  logic [7:0]   i_axis_master_tuser,
    output logic         o_wr_start,
    output logic [9:0]   o_length,
    output logic [7:0]   o_dwbe,
    output logic [127:0] o_data,
    output logic [3:0]   o_dw_vld,
    output logic [63:0]  o_addr,
`ifdef IPSL_PCIE_MWR_DROP_CNT_EN
    output logic [15:0]  o_drop_cnt,
`endif
    output logic [1:0]   o_bar_hit
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [10:0] MAX_LEN = 11'(MAX_LEN_DW);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RX,
        S_FLUSH,
        S_TX,
        S_GAP
    } state_t;

    state_t state;

    function automatic logic [8:0] beats_of(input logic [9:0] len);
        if (len == 10'd0) return 9'd256;
        return {1'b0, len[9:2]} + {8'd0, |len[1:0]};
    endfunction

    function automatic logic [3:0] last_mask(input logic [9:0] len);
        case (len[1:0])
            2'd1:    return 4'h1;
            2'd2:    return 4'h3;
            2'd3:    return 4'h7;
            default: return 4'hF;
        endcase
    endfunction

    logic        accept;
    logic [2:0]  hdr_fmt;
    logic [4:0]  hdr_type;
    logic [9:0]  hdr_len;
    logic [10:0] hdr_len_dw;
    logic        hdr_is_mwr;
    logic        hdr_drop;
    logic [63:0] hdr_addr;
    logic [1:0]  hdr_bar;

    assign accept     = i_axis_master_tvalid && o_axis_master_tready;
    assign hdr_fmt    = i_axis_master_tdata[31:29];
    assign hdr_type   = i_axis_master_tdata[28:24];
    assign hdr_len    = i_axis_master_tdata[9:0];
    assign hdr_len_dw = (hdr_len == 10'd0) ? 11'd1024 : {1'b0, hdr_len};
    assign hdr_is_mwr = ((hdr_fmt == 3'b010) || (hdr_fmt == 3'b011)) && (hdr_type == 5'd0);
    assign hdr_drop   = !hdr_is_mwr || (hdr_len_dw > MAX_LEN);
    assign hdr_addr   = hdr_fmt[0] ? {i_axis_master_tdata[95:64], i_axis_master_tdata[127:98], 2'b00}
                                   : {32'd0, i_axis_master_tdata[95:66], 2'b00};

    always_comb begin
        hdr_bar = 2'd3;
        if (i_axis_master_tuser[0])      hdr_bar = 2'd0;
        else if (i_axis_master_tuser[1]) hdr_bar = 2'd1;
        else if (i_axis_master_tuser[2]) hdr_bar = 2'd2;
    end

    logic unused_inputs;
    assign unused_inputs = ^{i_axis_master_tkeep, i_axis_master_tuser[7:6]};

    // Header fields are parked here until tlast, then copied to the outputs.
    logic [9:0]  hold_len;
    logic [7:0]  hold_dwbe;
    logic [63:0] hold_addr;
    logic [1:0]  hold_bar;
    logic        is_4dw;
    logic        drop_r;
    logic [31:0] carry;
    logic [8:0]  writes_left;
    logic [8:0]  tx_left;

    logic         wr_en;
    logic [127:0] wr_data;
    logic         rd_en;
    logic [127:0] rd_data;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   fifo_cnt;
    logic          fifo_empty;
    logic          fifo_full;
    logic [127:0]  mem [FIFO_DEPTH];

    // 3DW payload is shifted down one DW: the header beat's DW3 is payload DW0.
    always_comb begin
        wr_en   = 1'b0;
        wr_data = i_axis_master_tdata;
        if (state == S_RX && accept && !drop_r && writes_left != 9'd0) begin
            wr_en   = 1'b1;
            wr_data = is_4dw ? i_axis_master_tdata : {i_axis_master_tdata[95:0], carry};
        end else if (state == S_FLUSH && writes_left != 9'd0) begin
            wr_en   = 1'b1;
            wr_data = {96'd0, carry};
        end
    end

    assign rd_en      = (state == S_FLUSH) || (state == S_TX && tx_left != 9'd0);
    assign fifo_empty = (fifo_cnt == '0);
    assign fifo_full  = (fifo_cnt == (AW + 1)'(FIFO_DEPTH));
    // The residual beat written in FLUSH may be the very beat read in the same cycle.
    assign rd_data    = (wr_en && fifo_empty) ? wr_data : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= wr_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + AW'(1);
            if (rd_en) rd_ptr <= rd_ptr + AW'(1);
            case ({wr_en, rd_en})
                2'b10:   fifo_cnt <= fifo_cnt + (AW + 1)'(1);
                2'b01:   fifo_cnt <= fifo_cnt - (AW + 1)'(1);
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n) !(wr_en && fifo_full && !rd_en));
    a_no_underflow: assert property (@(posedge clk) disable iff (!rst_n) !(rd_en && fifo_empty && !wr_en));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state                <= S_IDLE;
            o_axis_master_tready <= 1'b0;
            o_wr_start           <= 1'b0;
            o_length             <= '0;
            o_dwbe               <= '0;
            o_data               <= '0;
            o_dw_vld             <= '0;
            o_addr               <= '0;
            o_bar_hit            <= '0;
            hold_len             <= '0;
            hold_dwbe            <= '0;
            hold_addr            <= '0;
            hold_bar             <= '0;
            is_4dw               <= 1'b0;
            drop_r               <= 1'b0;
            carry                <= '0;
            writes_left          <= '0;
            tx_left              <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    o_axis_master_tready <= 1'b1;
                    if (accept) begin
                        if (hdr_drop) begin
                            if (!i_axis_master_tlast) begin
                                drop_r <= 1'b1;
                                state  <= S_RX;
                            end
                        end else begin
                            hold_len    <= hdr_len;
                            hold_dwbe   <= i_axis_master_tdata[39:32];
                            hold_addr   <= hdr_addr;
                            hold_bar    <= hdr_bar;
                            is_4dw      <= hdr_fmt[0];
                            carry       <= i_axis_master_tdata[127:96];
                            writes_left <= beats_of(hdr_len);
                            if (i_axis_master_tlast) begin
                                o_length             <= hdr_len;
                                o_dwbe               <= i_axis_master_tdata[39:32];
                                o_addr               <= hdr_addr;
                                o_bar_hit            <= hdr_bar;
                                o_axis_master_tready <= 1'b0;
                                state                <= S_FLUSH;
                            end else begin
                                state <= S_RX;
                            end
                        end
                    end
                end
                S_RX: begin
                    if (accept) begin
                        if (!drop_r) carry <= i_axis_master_tdata[127:96];
                        if (wr_en) writes_left <= writes_left - 9'd1;
                        if (i_axis_master_tlast) begin
                            if (drop_r) begin
                                drop_r <= 1'b0;
                                state  <= S_IDLE;
                            end else begin
                                o_length             <= hold_len;
                                o_dwbe               <= hold_dwbe;
                                o_addr               <= hold_addr;
                                o_bar_hit            <= hold_bar;
                                o_axis_master_tready <= 1'b0;
                                state                <= S_FLUSH;
                            end
                        end
                    end
                end
                S_FLUSH: begin
                    if (wr_en) writes_left <= writes_left - 9'd1;
                    o_wr_start <= 1'b1;
                    o_data     <= rd_data;
                    tx_left    <= beats_of(o_length) - 9'd1;
                    o_dw_vld   <= (beats_of(o_length) == 9'd1) ? last_mask(o_length) : 4'hF;
                    state      <= S_TX;
                end
                S_TX: begin
                    if (tx_left != 9'd0) begin
                        o_data   <= rd_data;
                        tx_left  <= tx_left - 9'd1;
                        o_dw_vld <= (tx_left == 9'd1) ? last_mask(o_length) : 4'hF;
                    end else begin
                        o_wr_start <= 1'b0;
                        o_data     <= '0;
                        o_dw_vld   <= '0;
                        state      <= S_GAP;
                    end
                end
                S_GAP: begin
                    o_axis_master_tready <= 1'b1;
                    state                <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    logic drop_done;
    assign drop_done = accept && i_axis_master_tlast &&
                       ((state == S_IDLE && hdr_drop) || (state == S_RX && drop_r));

`ifdef IPSL_PCIE_MWR_DROP_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_drop_cnt <= '0;
        end else if (drop_done && o_drop_cnt != 16'hFFFF) begin
            o_drop_cnt <= o_drop_cnt + 16'd1;
        end
    end
`else
    logic unused_drop;
    assign unused_drop = drop_done;
`endif

endmodule
